// File: rtl/lifo_serializer_pkg.sv
// Shared types and constants for the lifo serializer and the lifo stage it drains.
package lifo_serializer_pkg;

  localparam int   LIFO_DATA_W = 10;
  localparam logic TX_IDLE     = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lifo_serializer_baud.sv
// Bit-period timer: bit_tick pulses for one cycle at the end of every CLKS_PER_BIT-cycle bit.
module lifo_serializer_baud
  import lifo_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int            BW   = cnt_width(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0] cnt;

  assign bit_tick = run && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lifo_serializer.sv
// Pops words from the lifo stage and sends each as an async-serial frame (start, LSB-first data, stop).
// Define LIFO_SERIALIZER_PARITY_EN to insert an even-parity bit between data and stop.
module lifo_serializer
  import lifo_serializer_pkg::*;
#(
  parameter int DATA_W       = LIFO_DATA_W,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              lifo_val,
  input  logic [DATA_W-1:0] lifo_data,
  output logic              lifo_read,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int            IDX_MAX   = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int            IW        = cnt_width(IDX_MAX);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_W - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   shift, shift_nx;
  logic [IW-1:0]       bit_idx, bit_idx_nx;
  logic [CNT_W-1:0]    words_nx;
  logic                tx_nx;
  logic                bit_tick;
`ifdef LIFO_SERIALIZER_PARITY_EN
  logic                parity_q, parity_nx;
`endif

  // Pop only from IDLE; reset masks the strobe so nothing is lost while held.
  assign lifo_read = (state == IDLE) && enable && lifo_val && !reset;
  assign busy      = (state != IDLE);

  lifo_serializer_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (lifo_read),
    .run     (busy),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bit_idx_nx = bit_idx;
    words_nx   = words_sent;
    tx_nx      = tx;
`ifdef LIFO_SERIALIZER_PARITY_EN
    parity_nx  = parity_q;
`endif
    case (state)
      IDLE: begin
        tx_nx = TX_IDLE;
        if (lifo_read) begin
          shift_nx   = lifo_data;
          bit_idx_nx = '0;
          tx_nx      = 1'b0;
          state_nx   = START;
`ifdef LIFO_SERIALIZER_PARITY_EN
          parity_nx  = ^lifo_data;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          tx_nx      = shift[0];
          bit_idx_nx = '0;
          state_nx   = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST_BIT) begin
            bit_idx_nx = '0;
`ifdef LIFO_SERIALIZER_PARITY_EN
            tx_nx    = parity_q;
            state_nx = PARITY;
`else
            tx_nx    = TX_IDLE;
            state_nx = STOP;
`endif
          end else begin
            // tx is registered, so present the next bit from the shifted value.
            shift_nx   = shift >> 1;
            tx_nx      = shift_nx[0];
            bit_idx_nx = bit_idx + 1'b1;
          end
        end
      end
`ifdef LIFO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          tx_nx      = TX_IDLE;
          bit_idx_nx = '0;
          state_nx   = STOP;
        end
      end
`endif
      STOP: begin
        tx_nx = TX_IDLE;
        if (bit_tick) begin
          if (bit_idx == LAST_STOP) begin
            bit_idx_nx = '0;
            words_nx   = words_sent + 1'b1;
            state_nx   = IDLE;
          end else begin
            bit_idx_nx = bit_idx + 1'b1;
          end
        end
      end
      default: begin
        tx_nx      = TX_IDLE;
        bit_idx_nx = '0;
        state_nx   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx         <= TX_IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      words_sent <= '0;
`ifdef LIFO_SERIALIZER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      tx         <= tx_nx;
      shift      <= shift_nx;
      bit_idx    <= bit_idx_nx;
      words_sent <= words_nx;
`ifdef LIFO_SERIALIZER_PARITY_EN
      parity_q   <= parity_nx;
`endif
    end
  end

endmodule

// File: tb/tb_lifo_serializer.sv
// Scoreboard bench for lifo_serializer: stimulus queues expected words, a serial-line monitor decodes and compares.
`timescale 1ns/1ps
module tb_lifo_serializer;

  localparam int DATA_W    = 10;
  localparam int CPB       = 4;
  localparam int STOP_BITS = 1;
  localparam int CNT_W     = 2;
`ifdef LIFO_SERIALIZER_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME = (1 + DATA_W + PAR_BITS + STOP_BITS) * CPB;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              lifo_val;
  logic [DATA_W-1:0] lifo_data;
  logic              lifo_read;
  logic              tx;
  logic              busy;
  logic [CNT_W-1:0]  words_sent;

  lifo_serializer #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (STOP_BITS),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .lifo_val  (lifo_val),
    .lifo_data (lifo_data),
    .lifo_read (lifo_read),
    .tx        (tx),
    .busy      (busy),
    .words_sent(words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] word;
    logic              par;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] stk[$];
  int                checks = 0;
  int                errors = 0;
  int                npops  = 0;
  longint            last_pop_t = -1;

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic update_lifo();
    lifo_val  = (stk.size() != 0);
    lifo_data = (stk.size() != 0) ? stk[$] : '0;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    stk.push_back(w);
    update_lifo();
  endtask

  task automatic expect_word(input logic [DATA_W-1:0] w, input logic p);
    exp_t e;
    e.word = w;
    e.par  = p;
    exp_q.push_back(e);
  endtask

  // One clock: sample the pop strobe before the edge, let the lifo model pop after it.
  task automatic cycle();
    logic rd;
    #1 rd = lifo_read;
    @(posedge clk);
    #1;
    if (rd) begin
      npops++;
      if (last_pop_t >= 0)
        check("pop_gap_at_least_frame_plus_1", (($time - last_pop_t) / 10 >= FRAME + 1) ? 1 : 0, 1);
      last_pop_t = $time;
      if (stk.size() != 0) void'(stk.pop_back());
      update_lifo();
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    last_pop_t = -1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic run_until_idle(output int busy_cyc, output int reads);
    logic prev_rd;
    prev_rd  = 1'b0;
    busy_cyc = 0;
    reads    = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (prev_rd) check("tx_low_after_read", tx, 0);
      prev_rd = lifo_read;
      if (lifo_read) reads++;
      if (busy) busy_cyc++;
      if (i > 0 && !busy && !lifo_read && !(enable && lifo_val)) return;
      cycle();
    end
    checks++;
    errors++;
    $display("FAIL run_timeout: busy=%0b after 1000 cycles, required 0", busy);
  endtask

  // Serial-line monitor: decodes frames at mid-bit and checks them against the queue.
  int                rx_cnt = -1;
  logic [DATA_W-1:0] rx_word;
  logic              rx_par;

  always @(negedge clk) begin
    if (reset) begin
      rx_cnt = -1;
    end else begin
      if (rx_cnt < 0) begin
        if (tx === 1'b0) rx_cnt = 0;
      end else begin
        rx_cnt++;
      end
      if (rx_cnt == CPB / 2) check("start_bit", tx, 0);
      for (int b = 0; b < DATA_W; b++)
        if (rx_cnt == (1 + b) * CPB + CPB / 2) rx_word[b] = tx;
      if (PAR_BITS != 0 && rx_cnt == (1 + DATA_W) * CPB + CPB / 2) rx_par = tx;
      if (rx_cnt == (1 + DATA_W + PAR_BITS) * CPB + CPB / 2) begin
        check("stop_bit", tx, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got word %0d, required no frame", rx_word);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("frame_word", rx_word, e.word);
`ifdef LIFO_SERIALIZER_PARITY_EN
          check("parity_bit", rx_par, e.par);
`endif
        end
        rx_cnt = -1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  int bc, rd, n0;
  logic [DATA_W-1:0] wrap_words [5];
  logic              wrap_par   [5];
  int                wrap_cnt   [5];
  int                bad;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    update_lifo();
    @(negedge clk);

    // Reset state, with a pop condition presented while reset is held
    push_word(10'h155);
    enable = 1'b1;
    cycle();
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_lifo_read", lifo_read, 0);
    check("rst_words_sent", words_sent, 0);
    check("rst_no_pop", npops, 0);
    stk.delete();
    update_lifo();
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // Single word 0000000101
    apply_reset();
    expect_word(10'b0000000101, 1'b0);
    push_word(10'b0000000101);
    enable = 1'b1;
    run_until_idle(bc, rd);
    check("single_reads", rd, 1);
    check("single_busy_cycles", bc, FRAME);
    check("single_words_sent", words_sent, 1);
    check("single_tx_idle", tx, 1);

    // Drain three: top of stack first
    apply_reset();
    push_word(10'b0000000001);
    push_word(10'b0000000010);
    push_word(10'b0000000100);
    expect_word(10'b0000000100, 1'b1);
    expect_word(10'b0000000010, 1'b1);
    expect_word(10'b0000000001, 1'b1);
    run_until_idle(bc, rd);
    check("drain_reads", rd, 3);
    check("drain_busy_cycles", bc, 3 * FRAME);
    check("drain_words_sent", words_sent, 3);
    check("drain_lifo_empty", lifo_val, 0);

    // Enable gating
    apply_reset();
    enable = 1'b0;
    push_word(10'h2C3);
    push_word(10'h0F0);
    bad = 0;
    n0  = npops;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (lifo_read || tx !== 1'b1) bad++;
      cycle();
    end
    check("gate_no_read_tx_high", bad, 0);
    check("gate_no_pop", npops - n0, 0);
    expect_word(10'h0F0, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    enable = 1'b0;
    run_until_idle(bc, rd);
    for (int i = 0; i < 20; i++) cycle();
    check("gate_single_pop", npops - n0, 1);
    check("gate_word_left", stk.size(), 1);
    check("gate_words_sent", words_sent, 1);
    stk.delete();
    update_lifo();

    // Reset mid-frame
    apply_reset();
    push_word(10'h0AA);
    push_word(10'h3C5);
    enable = 1'b1;
    n0 = npops;
    for (int i = 0; i < 21; i++) cycle();
    check("midrst_popped", npops - n0, 1);
    check("midrst_busy_before", busy, 1);
    reset = 1'b1;
    last_pop_t = -1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_lifo_read", lifo_read, 0);
    check("midrst_words_sent", words_sent, 0);
    n0 = npops;
    for (int i = 0; i < 3; i++) cycle();
    enable = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("midrst_no_pop", npops - n0, 0);
    check("midrst_tx_after", tx, 1);
    stk.delete();
    update_lifo();

    // Counter wrap at CNT_W=2
    apply_reset();
    wrap_words = '{10'h3FF, 10'h000, 10'h2AA, 10'h155, 10'h201};
    wrap_par   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    wrap_cnt   = '{1, 2, 3, 0, 1};
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_word(wrap_words[k], wrap_par[k]);
      push_word(wrap_words[k]);
      run_until_idle(bc, rd);
      check("wrap_words_sent", words_sent, wrap_cnt[k]);
    end

`ifdef LIFO_SERIALIZER_PARITY_EN
    // Parity: six ones -> 0, seven ones -> 1
    apply_reset();
    expect_word(10'b0101101011, 1'b0);
    push_word(10'b0101101011);
    run_until_idle(bc, rd);
    check("par_even_busy_cycles", bc, 52);
    expect_word(10'b0101101111, 1'b1);
    push_word(10'b0101101111);
    run_until_idle(bc, rd);
    check("par_odd_busy_cycles", bc, 52);
`endif

    enable = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
